// File: rtl/pc_gen_unit.sv
// pc_gen_unit: fetch-stage PC generator.
// Owns F_PC and selects the next fetch address from these sources:
// sequential, D-stage branch/J/JR redirect, exception entry, and ERET.
// If a redirect arrives while instruction memory is not ready, the target is
// parked in pend_pc until the fetch at F_PC is accepted.
// Optional build macro PC_GEN_ADDR_CHK_EN turns on the fetch address-error flag F_adel.
//
// state | meaning
// ------+-----------------------------------------------------------------
// RUN   | normal fetch; D-stage redirects are taken or buffered here
// HOLD  | redirect target buffered in pend_pc, waiting for imem acceptance
module pc_gen_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_PC    = 32'h0000_4180,
    parameter logic [31:0] IMEM_BASE = 32'h0000_3000,
    parameter logic [31:0] IMEM_SIZE = 32'h0000_4000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        imem_ready,
    input  logic [31:0] D_PC,
    input  logic [25:0] imm26,
    input  logic [2:0]  NPCop,
    input  logic [31:0] jreg,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] F_PC,
    output logic        F_valid,
    output logic        redir_pend,
    output logic        F_adel
);

    typedef enum logic {RUN, HOLD} state_t;

    state_t      state;
    logic [31:0] pend_pc;
    logic [31:0] d_pc4;
    logic [31:0] br_off;
    logic [31:0] target;
    logic        redir;
    logic        adv;

    // Redirect target from the instruction currently in D
    always_comb begin
        d_pc4  = D_PC + 32'd4;
        br_off = {{14{imm26[15]}}, imm26[15:0], 2'b00};
        target = F_PC + 32'd4;
        redir  = 1'b0;
        case (NPCop)
            3'd1: begin target = d_pc4 + br_off;                  redir = 1'b1; end
            3'd2: begin target = {d_pc4[31:28], imm26, 2'b00};    redir = 1'b1; end
            3'd3: begin target = jreg;                            redir = 1'b1; end
            default: ;
        endcase
        adv = imem_ready & ~stall_i;
    end

    // PC register and redirect-buffer state machine
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            F_PC       <= RESET_PC;
            F_valid    <= 1'b0;
            state      <= RUN;
            pend_pc    <= 32'd0;
            redir_pend <= 1'b0;
        end else begin
            F_valid <= 1'b1;
            if (exc_req) begin
                F_PC       <= EXC_PC;
                state      <= RUN;
                redir_pend <= 1'b0;
            end else if (eret_req) begin
                F_PC       <= epc;
                state      <= RUN;
                redir_pend <= 1'b0;
            end else begin
                case (state)
                    RUN: begin
                        if (redir) begin
                            if (adv) begin
                                F_PC <= target;
                            end else if (!stall_i) begin
                                // imem busy: park the target, delay slot fetch still pending
                                pend_pc    <= target;
                                state      <= HOLD;
                                redir_pend <= 1'b1;
                            end
                        end else if (adv) begin
                            F_PC <= F_PC + 32'd4;
                        end
                    end
                    HOLD: begin
                        // D holds the delay slot now, so NPCop is not looked at
                        if (adv) begin
                            F_PC       <= pend_pc;
                            state      <= RUN;
                            redir_pend <= 1'b0;
                        end
                    end
                    default: begin
                        state      <= RUN;
                        redir_pend <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef PC_GEN_ADDR_CHK_EN
    localparam logic ADDR_CHK_ON = 1'b1;
`else
    localparam logic ADDR_CHK_ON = 1'b0;
`endif

    localparam logic [31:0] IMEM_END = IMEM_BASE + IMEM_SIZE;

    logic addr_err;

    // Fetch address error; reported only, the PC still advances normally
    always_comb begin
        addr_err = (F_PC[1:0] != 2'b00) | (F_PC < IMEM_BASE) | (F_PC >= IMEM_END);
        F_adel   = ADDR_CHK_ON & F_valid & addr_err;
    end

endmodule

// File: tb/tb_pc_gen_unit.sv
// tb_pc_gen_unit: directed scenarios plus randomized traffic for pc_gen_unit,
// checked against a behavioural model (PC value plus a queue of parked redirects).
module tb_pc_gen_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        imem_ready;
    logic [31:0] D_PC;
    logic [25:0] imm26;
    logic [2:0]  NPCop;
    logic [31:0] jreg;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] F_PC;
    logic        F_valid;
    logic        redir_pend;
    logic        F_adel;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] pend_q[$];

    pc_gen_unit dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .imem_ready(imem_ready),
        .D_PC(D_PC), .imm26(imm26), .NPCop(NPCop), .jreg(jreg),
        .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
        .F_PC(F_PC), .F_valid(F_valid), .redir_pend(redir_pend), .F_adel(F_adel)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_target();
        logic [31:0] next_seq;
        next_seq = D_PC + 32'd4;
        case (NPCop)
            3'd1: return next_seq + 32'($signed(imm26[15:0])) * 32'd4;
            3'd2: return (next_seq & 32'hF000_0000) | (32'(imm26) * 32'd4);
            3'd3: return jreg;
            default: return m_pc + 32'd4;
        endcase
    endfunction

    function automatic logic exp_adel();
`ifdef PC_GEN_ADDR_CHK_EN
        return m_valid && ((m_pc % 4) != 0 || m_pc < 32'h3000 || m_pc >= 32'h7000);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_pc    = 32'h3000;
        m_valid = 1'b0;
        pend_q.delete();
    endtask

    // One clock edge: DUT samples inputs, model applies the same rules
    task automatic step();
        logic go;
        logic is_redir;
        @(posedge clk);
        go       = imem_ready && !stall_i;
        is_redir = (NPCop >= 3'd1 && NPCop <= 3'd3);
        m_valid  = 1'b1;
        if (exc_req) begin
            m_pc = 32'h4180;
            pend_q.delete();
        end else if (eret_req) begin
            m_pc = epc;
            pend_q.delete();
        end else if (pend_q.size() != 0) begin
            if (go) m_pc = pend_q.pop_front();
        end else if (is_redir) begin
            if (go) m_pc = ref_target();
            else if (!stall_i) pend_q.push_back(ref_target());
        end else if (go) begin
            m_pc = m_pc + 32'd4;
        end
        #1;
    endtask

    task automatic idle_inputs();
        stall_i = 0; imem_ready = 0; D_PC = 32'h3000; imm26 = '0; NPCop = 0;
        jreg = '0; exc_req = 0; eret_req = 0; epc = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        model_reset();
        #23;
        checks++; if (F_PC !== 32'h3000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", F_PC, 32'h3000); end
        checks++; if (F_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", F_valid); end
        checks++; if (redir_pend !== 1'b0) begin failures++; $display("FAIL reset_pend got=%b exp=0", redir_pend); end
        checks++; if (F_adel !== 1'b0) begin failures++; $display("FAIL reset_adel got=%b exp=0", F_adel); end
        @(negedge clk);
        reset = 1'b0;
        step();
        checks++; if (F_valid !== 1'b1) begin failures++; $display("FAIL first_edge_valid got=%b exp=1", F_valid); end
        checks++; if (F_PC !== 32'h3000) begin failures++; $display("FAIL first_edge_pc got=%h exp=3000", F_PC); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_seq;
        imem_ready = 1; NPCop = 0;
        for (int i = 1; i <= 3; i++) begin
            step();
            exp_seq = 32'h3000 + 32'(i) * 32'd4;
            checks++; if (F_PC !== exp_seq) begin failures++; $display("FAIL seq_%0d got=%h exp=%h", i, F_PC, exp_seq); end
        end
    endtask

    task automatic test_branch();
        D_PC = 32'h3010; NPCop = 1; imm26 = 26'h000FFFE; imem_ready = 1;
        step();
        checks++; if (F_PC !== 32'h300C) begin failures++; $display("FAIL branch_back got=%h exp=300c", F_PC); end
        checks++; if (F_PC !== m_pc) begin failures++; $display("FAIL branch_model got=%h exp=%h", F_PC, m_pc); end
    endtask

    task automatic test_jump_hold();
        D_PC = 32'h3020; NPCop = 2; imm26 = 26'h0000C00; imem_ready = 0;
        step();
        checks++; if (redir_pend !== 1'b1) begin failures++; $display("FAIL jhold_pend got=%b exp=1", redir_pend); end
        checks++; if (F_PC !== 32'h300C) begin failures++; $display("FAIL jhold_pc got=%h exp=300c", F_PC); end
        NPCop = 3; jreg = 32'h5555_0000;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (F_PC !== 32'h300C || redir_pend !== 1'b1) begin
                failures++; $display("FAIL jhold_wait_%0d pc=%h pend=%b exp pc=300c pend=1", i, F_PC, redir_pend);
            end
        end
        imem_ready = 1;
        step();
        checks++; if (F_PC !== 32'h3000) begin failures++; $display("FAIL jhold_release got=%h exp=3000", F_PC); end
        checks++; if (redir_pend !== 1'b0) begin failures++; $display("FAIL jhold_release_pend got=%b exp=0", redir_pend); end
    endtask

    task automatic test_stall_exc();
        stall_i = 1; NPCop = 3; jreg = 32'h3400; imem_ready = 1;
        step();
        checks++; if (F_PC !== 32'h3000 || redir_pend !== 1'b0) begin
            failures++; $display("FAIL stall_jr pc=%h pend=%b exp pc=3000 pend=0", F_PC, redir_pend);
        end
        exc_req = 1;
        step();
        checks++; if (F_PC !== 32'h4180) begin failures++; $display("FAIL exc_entry got=%h exp=4180", F_PC); end
        exc_req = 0; stall_i = 0;
    endtask

    task automatic test_eret_hold();
        logic [31:0] epcs[4];
        logic        adel_exp[4];
        epcs = '{32'h3044, 32'h3046, 32'h7000, 32'h6FFC};
`ifdef PC_GEN_ADDR_CHK_EN
        adel_exp = '{1'b0, 1'b1, 1'b1, 1'b0};
`else
        adel_exp = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 4; i++) begin
            D_PC = 32'h3100; NPCop = 1; imm26 = 26'h10; imem_ready = 0; stall_i = 0;
            step();
            checks++; if (redir_pend !== 1'b1) begin failures++; $display("FAIL eret_setup_%0d pend=%b exp=1", i, redir_pend); end
            eret_req = 1; epc = epcs[i];
            step();
            eret_req = 0; NPCop = 0;
            checks++; if (F_PC !== epcs[i] || redir_pend !== 1'b0) begin
                failures++; $display("FAIL eret_%0d pc=%h pend=%b exp pc=%h pend=0", i, F_PC, redir_pend, epcs[i]);
            end
            checks++; if (F_adel !== adel_exp[i]) begin failures++; $display("FAIL eret_adel_%0d got=%b exp=%b", i, F_adel, adel_exp[i]); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            stall_i    = ($urandom_range(0, 3) == 0);
            imem_ready = ($urandom_range(0, 3) != 0);
            D_PC       = 32'h3000 + (32'($urandom_range(0, 32'hFFF)) << 2);
            imm26      = 26'($urandom);
            NPCop      = 3'($urandom_range(0, 7));
            jreg       = ($urandom_range(0, 7) == 0) ? $urandom : 32'h3000 + (32'($urandom_range(0, 32'hFFF)) << 2);
            exc_req    = ($urandom_range(0, 24) == 0);
            eret_req   = ($urandom_range(0, 19) == 0);
            epc        = ($urandom_range(0, 3) == 0) ? $urandom : 32'h3000 + (32'($urandom_range(0, 32'hFFF)) << 2);
            step();
            checks++; if (F_PC !== m_pc || redir_pend !== (pend_q.size() != 0) || F_valid !== m_valid || F_adel !== exp_adel()) begin
                failures++;
                $display("FAIL random_%0d pc=%h pend=%b valid=%b adel=%b exp pc=%h pend=%b valid=%b adel=%b",
                         n, F_PC, redir_pend, F_valid, F_adel, m_pc, (pend_q.size() != 0), m_valid, exp_adel());
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_hold();
        idle_inputs();
        D_PC = 32'h3200; NPCop = 2; imm26 = 26'h123;
        step();
        checks++; if (redir_pend !== 1'b1) begin failures++; $display("FAIL rst_hold_setup pend=%b exp=1", redir_pend); end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checks++; if (F_PC !== 32'h3000 || redir_pend !== 1'b0 || F_valid !== 1'b0) begin
            failures++; $display("FAIL rst_mid_hold pc=%h pend=%b valid=%b exp pc=3000 pend=0 valid=0", F_PC, redir_pend, F_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        NPCop = 0;
        step();
        checks++; if (F_valid !== 1'b1 || F_PC !== 32'h3000) begin
            failures++; $display("FAIL rst_mid_hold_after valid=%b pc=%h exp valid=1 pc=3000", F_valid, F_PC);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump_hold();
        test_stall_exc();
        test_eret_hold();
        test_random();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
